pgm_sequencer: RTL and testbench

//  Parametrised program-address sequencer; successor to the single-register program counter.

---
 rtl/pgm_sequencer_pkg.sv | 45 ++++
 rtl/pgm_sequencer_ret_stack.sv | 61 ++++++
 rtl/pgm_sequencer.sv | 117 +++++++++++
 tb/tb_pgm_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pgm_sequencer_pkg.sv
// Purpose: shared constants, action encoding and command decode for the program sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a; stall is expressed by the sequencer's en input.
package pgm_sequencer_pkg;

    // Default build constants: address width, return-stack depth and reset vector.
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_STACK_DEPTH = 4;
    localparam int DEF_RESET_VEC   = 0;

    // One decoded control action per enabled cycle.
    typedef enum logic [1:0] {
        ACT_NONE   = 2'd0,
        ACT_BRANCH = 2'd1,
        ACT_CALL   = 2'd2,
        ACT_RET    = 2'd3
    } action_t;

    // Decoded request: the chosen action plus a flag for conflicting requests.
    typedef struct packed {
        action_t act;
        logic    multi;
    } decode_t;

    // Collapse the three request lines into one action.
    // multi is set when two or more requests are high. In that case act is
    // meaningless and the caller must treat the cycle as a hold.
    function automatic decode_t decodeAction(input logic branchReq,
                                             input logic callReq,
                                             input logic retReq);
        decode_t d;
        d.multi = (branchReq & callReq) | (branchReq & retReq) | (callReq & retReq);
        if (branchReq) begin
            d.act = ACT_BRANCH;
        end else if (callReq) begin
            d.act = ACT_CALL;
        end else if (retReq) begin
            d.act = ACT_RET;
        end else begin
            d.act = ACT_NONE;
        end
        return d;
    endfunction

endpackage

// File: rtl/pgm_sequencer_ret_stack.sv
// Purpose: single-port return-address LIFO (push/pop/top) with occupancy count.
// Latency: push/pop take effect on the next clk edge; top/full/empty/depth are combinational from state.
// Backpressure: a push while full and a pop while empty are ignored. The caller flags these as errors.
module ret_stack
    import pgm_sequencer_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [ADDR_W-1:0]  pushData,
    output logic [ADDR_W-1:0]  topData,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    // Round the storage up to a power of two so that the index width is exact.
    // This also keeps a one-entry stack legal.
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int MEM_N = 1 << IDX_W;

    logic [ADDR_W-1:0] mem [MEM_N];
    logic [IDX_W-1:0]  wrIdx;
    logic [IDX_W-1:0]  topIdx;
    logic              doPush;
    logic              doPop;

    assign full   = (depth == DEPTH_W'(STACK_DEPTH));
    assign empty  = (depth == '0);
    assign wrIdx  = IDX_W'(depth);
    assign topIdx = IDX_W'(depth - DEPTH_W'(1));
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;

    // The top entry is only meaningful while the stack is not empty.
    assign topData = mem[topIdx];

    // Occupancy counter. It is cleared by reset, and push and pop are never requested together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            depth <= '0;
        end else if (doPush) begin
            depth <= depth + DEPTH_W'(1);
        end else if (doPop) begin
            depth <= depth - DEPTH_W'(1);
        end
    end

    // Entry storage is not cleared on reset. A push in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset && doPush) begin
            mem[wrIdx] <= pushData;
        end
    end

endmodule

// File: rtl/pgm_sequencer.sv
// Purpose: instruction fetch address generator: increment, branch, call and return, with sticky error flags.
// Latency: 1 cycle from an enabled request to the new pc_out.
// Backpressure: en=0 stalls every piece of state. Illegal requests hold pc and raise sticky flags.
module pgm_sequencer
    import pgm_sequencer_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                STACK_DEPTH = DEF_STACK_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(DEF_RESET_VEC),
    parameter int                DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               branch,
    input  logic               call,
    input  logic               ret,
    input  logic [ADDR_W-1:0]  target,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [DEPTH_W-1:0] depth_out,
    output logic               stack_full,
    output logic               stack_empty,
    output logic               err_ovf,
    output logic               err_unf,
    output logic               err_cmd
);

    decode_t           dec;
    logic [ADDR_W-1:0] pcReg;
    logic [ADDR_W-1:0] pcPlus1;
    logic [ADDR_W-1:0] nextPc;
    logic [ADDR_W-1:0] topData;
    logic              doPush;
    logic              doPop;
    logic              setOvf;
    logic              setUnf;
    logic              setCmd;

    assign dec     = decodeAction(branch, call, ret);
    assign pcPlus1 = pcReg + ADDR_W'(1);
    assign pc_out  = pcReg;

    ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_W     (DEPTH_W)
    ) u_retStack (
        .clk      (clk),
        .reset    (reset),
        .push     (doPush),
        .pop      (doPop),
        .pushData (pcPlus1),
        .topData  (topData),
        .depth    (depth_out),
        .full     (stack_full),
        .empty    (stack_empty)
    );

    // Action decode and next-pc select. The error decisions are made here, not in the stack.
    always_comb begin
        nextPc = pcReg;
        doPush = 1'b0;
        doPop  = 1'b0;
        setOvf = 1'b0;
        setUnf = 1'b0;
        setCmd = 1'b0;
        if (en) begin
            if (dec.multi) begin
                setCmd = 1'b1;
            end else begin
                case (dec.act)
                    ACT_NONE: begin
                        nextPc = pcPlus1;
                    end
                    ACT_BRANCH: begin
                        nextPc = target;
                    end
                    ACT_CALL: begin
                        if (stack_full) begin
                            setOvf = 1'b1;
                        end else begin
                            doPush = 1'b1;
                            nextPc = target;
                        end
                    end
                    ACT_RET: begin
                        if (stack_empty) begin
                            setUnf = 1'b1;
                        end else begin
                            doPop  = 1'b1;
                            nextPc = topData;
                        end
                    end
                    default: begin
                        nextPc = pcReg;
                    end
                endcase
            end
        end
    end

    // The pc register and the sticky error flags. Only reset clears the flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pcReg   <= RESET_VEC;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
            err_cmd <= 1'b0;
        end else begin
            pcReg   <= nextPc;
            err_ovf <= err_ovf | setOvf;
            err_unf <= err_unf | setUnf;
            err_cmd <= err_cmd | setCmd;
        end
    end

endmodule

// File: tb/tb_pgm_sequencer.sv
// Purpose: self-checking bench. It runs two sequencer builds (reset vectors 00 and A0) on shared stimulus.
// Latency: a model steps on each rising edge, and outputs are compared on every falling edge.
// Backpressure: stall and illegal-request cases are exercised through en and conflicting requests.
module tb_pgm_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       branch = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] target = 8'h00;

    logic [7:0] pcOut   [2];
    logic [2:0] depthOut[2];
    logic       fullO   [2];
    logic       emptyO  [2];
    logic       ovfO    [2];
    logic       unfO    [2];
    logic       cmdO    [2];

    int passCnt  = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    pgm_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_VEC(8'h00)) dut0 (
        .clk(clk), .reset(reset), .en(en), .branch(branch), .call(call), .ret(ret),
        .target(target), .pc_out(pcOut[0]), .depth_out(depthOut[0]),
        .stack_full(fullO[0]), .stack_empty(emptyO[0]),
        .err_ovf(ovfO[0]), .err_unf(unfO[0]), .err_cmd(cmdO[0])
    );

    pgm_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_VEC(8'hA0)) dut1 (
        .clk(clk), .reset(reset), .en(en), .branch(branch), .call(call), .ret(ret),
        .target(target), .pc_out(pcOut[1]), .depth_out(depthOut[1]),
        .stack_full(fullO[1]), .stack_empty(emptyO[1]),
        .err_ovf(ovfO[1]), .err_unf(unfO[1]), .err_cmd(cmdO[1])
    );

    // Behavioural model: an integer pc, an array-plus-count stack and three flags per build.
    int mPc   [2];
    int mStk  [2][4];
    int mDep  [2];
    bit mOvf  [2];
    bit mUnf  [2];
    bit mCmd  [2];
    int mRv   [2] = '{32'h00, 32'hA0};
    bit modelValid = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                mPc[k] = mRv[k];
                mDep[k] = 0;
                mOvf[k] = 0; mUnf[k] = 0; mCmd[k] = 0;
            end else if (en) begin
                if (int'(branch) + int'(call) + int'(ret) > 1) begin
                    mCmd[k] = 1;
                end else if (branch) begin
                    mPc[k] = int'(target);
                end else if (call) begin
                    if (mDep[k] == 4) begin
                        mOvf[k] = 1;
                    end else begin
                        mStk[k][mDep[k]] = (mPc[k] + 1) % 256;
                        mDep[k] = mDep[k] + 1;
                        mPc[k] = int'(target);
                    end
                end else if (ret) begin
                    if (mDep[k] == 0) begin
                        mUnf[k] = 1;
                    end else begin
                        mDep[k] = mDep[k] - 1;
                        mPc[k] = mStk[k][mDep[k]];
                    end
                end else begin
                    mPc[k] = (mPc[k] + 1) % 256;
                end
            end
        end
        if (!reset) modelValid = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            passCnt++;
        end
    endtask

    // Continuous comparison of both builds against the model on every falling edge.
    always @(negedge clk) begin
        if (modelValid) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("pc[%0d]", k),    32'(pcOut[k]),    32'(mPc[k]));
                chk($sformatf("depth[%0d]", k), 32'(depthOut[k]), 32'(mDep[k]));
                chk($sformatf("full[%0d]", k),  32'(fullO[k]),    32'(mDep[k] == 4));
                chk($sformatf("empty[%0d]", k), 32'(emptyO[k]),   32'(mDep[k] == 0));
                chk($sformatf("ovf[%0d]", k),   32'(ovfO[k]),     32'(mOvf[k]));
                chk($sformatf("unf[%0d]", k),   32'(unfO[k]),     32'(mUnf[k]));
                chk($sformatf("cmd[%0d]", k),   32'(cmdO[k]),     32'(mCmd[k]));
            end
        end
    end

    // Apply one cycle of inputs after the falling-edge compare, then return just after the rising edge.
    task automatic tick(input logic r, input logic e, input logic b, input logic c,
                        input logic rt, input logic [7:0] t);
        @(negedge clk);
        #2;
        reset = r; en = e; branch = b; call = c; ret = rt; target = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset for one cycle, then idle increments from 00 (and from A0 on the second build).
        tick(0, 1, 0, 0, 0, 8'h00);
        chk("t1 pc after reset", 32'(pcOut[0]), 32'h00);
        chk("t1 pc A0 build",    32'(pcOut[1]), 32'hA0);
        chk("t1 empty",          32'(emptyO[0]), 32'h1);
        tick(1, 1, 0, 0, 0, 8'h00);
        chk("t1 pc 01", 32'(pcOut[0]), 32'h01);
        tick(1, 1, 0, 0, 0, 8'h00);
        tick(1, 1, 0, 0, 0, 8'h00);
        chk("t1 pc 03", 32'(pcOut[0]), 32'h03);
        chk("t1 errs",  32'({ovfO[0], unfO[0], cmdO[0]}), 32'h0);

        // 2: wrap past FF, with a stall whose requests must all be ignored.
        tick(1, 1, 1, 0, 0, 8'hFE);
        chk("t2 pc FE", 32'(pcOut[0]), 32'hFE);
        tick(1, 1, 0, 0, 0, 8'h00);
        chk("t2 pc FF", 32'(pcOut[0]), 32'hFF);
        tick(1, 1, 0, 0, 0, 8'h00);
        chk("t2 pc wrap 00", 32'(pcOut[0]), 32'h00);
        tick(1, 0, 1, 1, 1, 8'h77);
        tick(1, 0, 0, 1, 0, 8'h77);
        chk("t2 stall hold", 32'(pcOut[0]), 32'h00);
        chk("t2 stall no err", 32'({ovfO[0], unfO[0], cmdO[0]}), 32'h0);
        chk("t2 stall depth", 32'(depthOut[0]), 32'h0);
        tick(1, 1, 0, 0, 0, 8'h00);
        chk("t2 pc 01", 32'(pcOut[0]), 32'h01);

        // 3: nested call and return.
        tick(1, 1, 1, 0, 0, 8'h10);
        tick(1, 1, 0, 1, 0, 8'h40);
        chk("t3 call1 pc", 32'(pcOut[0]), 32'h40);
        chk("t3 call1 depth", 32'(depthOut[0]), 32'h1);
        tick(1, 1, 0, 1, 0, 8'h80);
        chk("t3 call2 pc", 32'(pcOut[0]), 32'h80);
        chk("t3 call2 depth", 32'(depthOut[0]), 32'h2);
        tick(1, 1, 0, 0, 1, 8'h00);
        chk("t3 ret1 pc", 32'(pcOut[0]), 32'h41);
        chk("t3 ret1 depth", 32'(depthOut[0]), 32'h1);
        tick(1, 1, 0, 0, 1, 8'h00);
        chk("t3 ret2 pc", 32'(pcOut[0]), 32'h11);
        chk("t3 ret2 depth", 32'(depthOut[0]), 32'h0);

        // 4: fill the stack, overflow it, then drain it in LIFO order.
        tick(1, 1, 1, 0, 0, 8'h20);
        for (int i = 0; i < 4; i++) tick(1, 1, 0, 1, 0, 8'h30 + 8'(i));
        chk("t4 full", 32'(fullO[0]), 32'h1);
        chk("t4 pc 33", 32'(pcOut[0]), 32'h33);
        tick(1, 1, 0, 1, 0, 8'h50);
        chk("t4 ovf pc holds", 32'(pcOut[0]), 32'h33);
        chk("t4 ovf flag", 32'(ovfO[0]), 32'h1);
        chk("t4 ovf depth", 32'(depthOut[0]), 32'h4);
        begin
            logic [7:0] expRet [4] = '{8'h33, 8'h32, 8'h31, 8'h21};
            for (int i = 0; i < 4; i++) begin
                tick(1, 1, 0, 0, 1, 8'h00);
                chk($sformatf("t4 ret%0d pc", i), 32'(pcOut[0]), 32'(expRet[i]));
            end
        end
        chk("t4 drained empty", 32'(emptyO[0]), 32'h1);

        // 5: underflow and conflicting requests, both sticky through idle cycles.
        tick(1, 1, 1, 0, 0, 8'h05);
        tick(1, 1, 0, 0, 1, 8'h00);
        chk("t5 unf pc holds", 32'(pcOut[0]), 32'h05);
        chk("t5 unf flag", 32'(unfO[0]), 32'h1);
        tick(1, 1, 1, 1, 0, 8'h60);
        chk("t5 cmd pc holds", 32'(pcOut[0]), 32'h05);
        chk("t5 cmd flag", 32'(cmdO[0]), 32'h1);
        chk("t5 cmd depth", 32'(depthOut[0]), 32'h0);
        tick(1, 1, 0, 0, 0, 8'h00);
        tick(1, 1, 0, 0, 0, 8'h00);
        chk("t5 pc 07", 32'(pcOut[0]), 32'h07);
        chk("t5 flags sticky", 32'({ovfO[0], unfO[0], cmdO[0]}), 32'h7);

        // 6: reset arrives together with a call while two entries are stacked.
        tick(1, 1, 0, 1, 0, 8'h90);
        tick(1, 1, 0, 1, 0, 8'h91);
        chk("t6 depth 2", 32'(depthOut[0]), 32'h2);
        tick(0, 1, 0, 1, 0, 8'h92);
        chk("t6 pc reset", 32'(pcOut[0]), 32'h00);
        chk("t6 pc A0", 32'(pcOut[1]), 32'hA0);
        chk("t6 depth A0", 32'(depthOut[1]), 32'h0);
        chk("t6 flags A0", 32'({ovfO[1], unfO[1], cmdO[1]}), 32'h0);
        tick(1, 1, 0, 0, 0, 8'h00);
        chk("t6 A0 inc", 32'(pcOut[1]), 32'hA1);
        tick(1, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        #2;

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
